// File: rtl/relu_tile_sequencer.sv
// relu_tile_sequencer: per-tile handshake, watchdog-guarded wait and write strobe for the ReLU array
module relu_tile_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   tile_count,
  input  logic              abort,
  input  logic              tile_valid,
  output logic              tile_ack,
  output logic              relu_in_ready,
  input  logic              relu_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [ADDR_W:0] MAX_TILES = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0] cnt;
  logic [WW-1:0] wdog;
  logic last_tile, relu_hit, wdog_exp;
  assign last_tile = {1'b0, idx} == cnt - (ADDR_W+1)'(1);
  // first WAIT cycle masks a relu_ready level left over from the previous tile
  assign relu_hit = relu_ready && wdog != '0;
  assign wdog_exp = wdog == WW'(TIMEOUT - 1);
  assign tile_ack = state == ISSUE && tile_valid;
  assign relu_in_ready = tile_ack;
  assign wr_en = state == STORE;
  assign wr_addr = idx;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_n = tile_count == '0 ? DONE : ISSUE;
        ISSUE:   if (tile_valid) state_n = WAIT;
        WAIT:    state_n = relu_hit ? STORE : wdog_exp ? DONE : WAIT;
        STORE:   state_n = last_tile ? DONE : ISSUE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      wdog <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (abort) begin
        idx <= '0;
        wdog <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            timeout_err <= 1'b0;
            idx <= '0;
            cnt <= tile_count > MAX_TILES ? MAX_TILES : tile_count;
          end
          ISSUE: if (tile_valid) wdog <= '0;
          WAIT: begin
            wdog <= wdog + WW'(1);
            if (!relu_hit && wdog_exp) timeout_err <= 1'b1;
          end
          STORE: if (!last_tile) idx <= idx + ADDR_W'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_relu_tile_sequencer.sv
// tb_relu_tile_sequencer: scoreboard bench; stimulus queues expected ack/write/done events, monitor pops them
module tb_relu_tile_sequencer;
  localparam int ADDR_W = 3;
  localparam int K_ACK = 0, K_WR = 1, K_DONE = 2;
  typedef struct {int kind; int addr; int gap;} ev_t;
  logic clk = 0, rst = 1, start = 0, abort = 0, tile_valid = 0, relu_ready = 0;
  logic [ADDR_W:0] tile_count = '0;
  logic tile_ack, relu_in_ready, wr_en, busy, done, timeout_err;
  logic [ADDR_W-1:0] wr_addr;
  int checks = 0, failures = 0;
  int mode = 0;
  int cyc = 0, last = 0;
  logic d1 = 0, d2 = 0;
  ev_t q[$];

  relu_tile_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_count(tile_count), .abort(abort),
    .tile_valid(tile_valid), .tile_ack(tile_ack), .relu_in_ready(relu_in_ready),
    .relu_ready(relu_ready), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // array model: mode 0 raises relu_ready two cycles after an ack, 1 stuck high, 2 stuck low
  always @(negedge clk) begin
    relu_ready = (mode == 1) || (mode == 0 && d2);
    d2 = d1;
    d1 = tile_ack;
  end

  always @(negedge clk) begin
    int k;
    ev_t e;
    cyc++;
    k = tile_ack ? K_ACK : wr_en ? K_WR : done ? K_DONE : -1;
    if (!rst && k >= 0) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event kind=%0d addr=%0d expected none", k, wr_addr);
      end else begin
        e = q.pop_front();
        if (e.kind != k || (k == K_WR && e.addr != int'(wr_addr)) ||
            (e.gap != 0 && cyc - last != e.gap) || relu_in_ready !== tile_ack) begin
          failures++;
          $display("FAIL event got kind=%0d addr=%0d gap=%0d rir=%b expected kind=%0d addr=%0d gap=%0d",
                   k, wr_addr, cyc - last, relu_in_ready, e.kind, e.addr, e.gap);
        end
      end
      last = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int addr, input int gap);
    ev_t e;
    e.kind = kind; e.addr = addr; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_job(input int n);
    for (int i = 0; i < n; i++) begin
      push(K_ACK, 0, i == 0 ? 0 : 1);
      push(K_WR, i, 3);
    end
    push(K_DONE, 0, n == 0 ? 0 : 1);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic do_start(input int n);
    start = 1;
    tile_count = (ADDR_W+1)'(n);
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 80 && busy; i++) tick();
    check({name, "_idle"}, int'(busy), 0);
    check({name, "_pending"}, q.size(), 0);
  endtask

  function automatic int outs();
    return int'({tile_ack, relu_in_ready, wr_en, wr_addr, busy, done, timeout_err});
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    check("outs_in_reset", outs(), 0);
    rst = 0;
    repeat (5) begin
      tick();
      check("outs_after_reset", outs(), 0);
    end
    // three tiles, always valid; a start pulse mid-job must be ignored
    tile_valid = 1;
    push_job(3);
    do_start(3);
    tick(); tick();
    do_start(0);
    wait_idle("job3");
    // empty job: one DONE cycle only
    push_job(0);
    do_start(0);
    check("zero_busy", int'(busy), 1);
    check("zero_done", int'(done), 1);
    tick();
    check("zero_busy_after", int'(busy), 0);
    check("zero_pending", q.size(), 0);
    // relu_ready stuck high still spaces writes 4 cycles apart
    mode = 1;
    push_job(2);
    do_start(2);
    wait_idle("stuck1");
    // relu_ready stuck low: 16 WAIT cycles then abort-by-watchdog
    mode = 2;
    push(K_ACK, 0, 0);
    push(K_DONE, 0, 17);
    do_start(1);
    wait_idle("timeout");
    check("timeout_err_set", int'(timeout_err), 1);
    tick();
    check("timeout_err_sticky", int'(timeout_err), 1);
    mode = 0;
    repeat (3) tick();
    push_job(1);
    do_start(1);
    check("timeout_err_cleared", int'(timeout_err), 0);
    wait_idle("after_timeout");
    // abort on second WAIT cycle of tile 1
    push(K_ACK, 0, 0);
    push(K_WR, 0, 3);
    push(K_ACK, 0, 1);
    do_start(4);
    repeat (6) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_addr", int'(wr_addr), 0);
    repeat (4) tick();
    check("abort_no_done", q.size(), 0);
    push_job(1);
    do_start(1);
    wait_idle("after_abort");
    // start together with abort in IDLE
    start = 1; abort = 1; tile_count = 4'd2;
    tick();
    start = 0; abort = 0;
    check("start_abort_busy", int'(busy), 0);
    repeat (3) tick();
    // full-size job and a clamped oversize request
    push_job(8);
    do_start(8);
    wait_idle("job8");
    push_job(8);
    do_start(12);
    wait_idle("clamp12");
    // async reset during STORE
    push(K_ACK, 0, 0);
    push(K_WR, 0, 3);
    do_start(2);
    for (int i = 0; i < 20 && !wr_en; i++) begin
      @(negedge clk);
      #1;
    end
    check("store_seen", int'(wr_en), 1);
    #2 rst = 1;
    #1 check("rst_drops_wr_en", int'(wr_en), 0);
    check("rst_outs", outs(), 0);
    tick();
    rst = 0;
    repeat (8) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_no_events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
